// File: rtl/fmt_pkg.sv
// Shared types and helpers for the stream formatter.
//   fmt_mode_e     : CHAR / DEC / HEX / STR request modes
//   fmt_state_e    : formatter FSM states
//   ASCII_SPACE/_0 : character constants
//   MAX_DEC_DIGITS : decimal digits needed for a w-bit unsigned value
//   hex_ascii      : nibble -> lowercase hex character
package fmt_pkg;

  typedef enum logic [1:0] {
    FMT_CHAR = 2'd0,
    FMT_DEC  = 2'd1,
    FMT_HEX  = 2'd2,
    FMT_STR  = 2'd3
  } fmt_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_PAD,
    ST_EMIT,
    ST_FIN
  } fmt_state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_0     = 8'h30;

  // ceil(w * log10(2)); 0.30103 slightly over-estimates log10(2), which only
  // matters when w*log10(2) is an exact integer (never for w > 0).
  function automatic int MAX_DEC_DIGITS(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

  // 'a' - 10 = 8'h57
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (ASCII_0 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/fmt_stream_formatter_if.sv
// Request / character-stream bundle for fmt_stream_formatter.
//   master : request producer and character sink (drives req_*, out_ready)
//   slave  : the formatter (drives req_ready, out_*, done, busy)
interface fmt_stream_formatter_if import fmt_pkg::*; #(
  parameter int DATA_W      = 32,
  parameter int STR_BYTES   = 16,
  parameter int FIELD_W_MAX = 32
);
  localparam int WW = $clog2(FIELD_W_MAX + 1);

  logic                   req_valid;
  logic                   req_ready;
  fmt_mode_e              req_mode;
  logic [WW-1:0]          req_width;
  logic [DATA_W-1:0]      req_data;
  logic [8*STR_BYTES-1:0] req_str;
  logic                   out_valid;
  logic                   out_ready;
  logic [7:0]             out_char;
  logic                   out_last;
  logic                   done;
  logic                   busy;

  modport master (
    output req_valid, req_mode, req_width, req_data, req_str, out_ready,
    input  req_ready, out_valid, out_char, out_last, done, busy
  );

  modport slave (
    input  req_valid, req_mode, req_width, req_data, req_str, out_ready,
    output req_ready, out_valid, out_char, out_last, done, busy
  );

endinterface

// File: rtl/fmt_char_lifo.sv
// Character LIFO holding converted digits least-significant-first so that
// popping yields them most-significant-first.
//   clk, rst_n   : clock, async active-low reset (clears contents)
//   clr_i        : drop all entries
//   push_i/_data : push one character
//   pop_i        : discard top entry
//   top_o        : current top (8'h00 when empty)
//   count_o      : number of stored entries
module fmt_char_lifo #(
  parameter  int DEPTH = 10,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [7:0]       push_data_i,
  input  logic             pop_i,
  output logic [7:0]       top_o,
  output logic [CNT_W-1:0] count_o
);

  logic [DEPTH-1:0][7:0] mem_q;
  logic [CNT_W-1:0]      cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (push_i) begin
      mem_q[cnt_q] <= push_data_i;
      cnt_q        <= cnt_q + CNT_W'(1);
    end else if (pop_i) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign top_o   = (cnt_q == '0) ? 8'h00 : mem_q[cnt_q - CNT_W'(1)];
  assign count_o = cnt_q;

endmodule

// File: rtl/fmt_stream_formatter.sv
// Sequential ASCII field formatter: one value per request, streamed out one
// character per beat, right-justified in a minimum field width.
//   clk, rst_n : clock, async active-low reset (aborts any request)
//   bus        : request handshake, character stream, done/busy status
module fmt_stream_formatter import fmt_pkg::*; #(
  parameter int DATA_W      = 32,
  parameter int STR_BYTES   = 16,
  parameter int FIELD_W_MAX = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fmt_stream_formatter_if.slave  bus
);

  localparam int WW      = $clog2(FIELD_W_MAX + 1);
  localparam int DEC_D   = MAX_DEC_DIGITS(DATA_W);
  // ceil keeps room for a partial top nibble when DATA_W is not a multiple of 4
  localparam int HEX_D   = (DATA_W + 3) / 4;
  localparam int LIFO_D  = (DEC_D > HEX_D) ? DEC_D : HEX_D;
  localparam int LCW     = $clog2(LIFO_D + 1);
  localparam int LEN_MAX = (STR_BYTES > LIFO_D) ? STR_BYTES : LIFO_D;
  localparam int LBW     = $clog2(LEN_MAX + 1);
  // one spare bit so width - len can never wrap
  localparam int CW      = ((WW > LBW) ? WW : LBW) + 1;

  localparam logic [DATA_W-1:0] TEN = DATA_W'(10);

  fmt_state_e             state_q, state_d;
  fmt_mode_e              mode_q, mode_d;
  logic [WW-1:0]          width_q, width_d;
  logic [DATA_W-1:0]      val_q, val_d;
  logic [8*STR_BYTES-1:0] str_q, str_d;
  logic [CW-1:0]          pad_q, pad_d;   // spaces still to send
  logic [CW-1:0]          rem_q, rem_d;   // content characters still to send

  logic          push, pop, lifo_clr;
  logic [7:0]    push_char, lifo_top;
  logic [LCW-1:0] lifo_cnt;
  logic          conv_done;
  logic [CW-1:0] conv_len, str_len, width_ext, sidx;
  logic [7:0]    str_byte;

  fmt_char_lifo #(.DEPTH(LIFO_D)) u_lifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (lifo_clr),
    .push_i      (push),
    .push_data_i (push_char),
    .pop_i       (pop),
    .top_o       (lifo_top),
    .count_o     (lifo_cnt)
  );

  assign width_ext = CW'(width_q);

  // Highest non-zero byte sets the length; zero bytes below it are content.
  always_comb begin
    str_len = '0;
    for (int b = 0; b < STR_BYTES; b++)
      if (str_q[8*b +: 8] != 8'h00) str_len = CW'(b + 1);
  end

  // Content is read MSB-side first: byte index rem-1 counted from the LSB.
  assign sidx     = rem_q - CW'(1);
  assign str_byte = 8'(str_q >> {sidx, 3'b000});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= FMT_CHAR;
      width_q <= '0;
      val_q   <= '0;
      str_q   <= '0;
      pad_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      width_q <= width_d;
      val_q   <= val_d;
      str_q   <= str_d;
      pad_q   <= pad_d;
      rem_q   <= rem_d;
    end
  end

  // Next state
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    width_d   = width_q;
    val_d     = val_q;
    str_d     = str_q;
    pad_d     = pad_q;
    rem_d     = rem_q;
    push      = 1'b0;
    push_char = 8'h00;
    pop       = 1'b0;
    lifo_clr  = 1'b0;
    conv_done = 1'b0;
    conv_len  = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          mode_d   = bus.req_mode;
          width_d  = (bus.req_width > WW'(FIELD_W_MAX)) ? WW'(FIELD_W_MAX) : bus.req_width;
          val_d    = bus.req_data;
          str_d    = bus.req_str;
          lifo_clr = 1'b1;
          state_d  = ST_CONV;
        end
      end
      ST_CONV: begin
        case (mode_q)
          FMT_CHAR: begin
            push      = 1'b1;
            push_char = val_q[7:0];
            conv_done = 1'b1;
            conv_len  = CW'(1);
          end
          FMT_DEC: begin
            push      = 1'b1;
            push_char = ASCII_0 + 8'(val_q % TEN);
            val_d     = val_q / TEN;
            conv_done = (val_d == '0);
            conv_len  = CW'(lifo_cnt) + CW'(1);
          end
          FMT_HEX: begin
            push      = 1'b1;
            push_char = hex_ascii(val_q[3:0]);
            val_d     = val_q >> 4;
            conv_done = (val_d == '0);
            conv_len  = CW'(lifo_cnt) + CW'(1);
          end
          FMT_STR: begin
            conv_done = 1'b1;
            conv_len  = str_len;
          end
        endcase
        if (conv_done) begin
          pad_d = (width_ext > conv_len) ? width_ext - conv_len : '0;
          rem_d = conv_len;
          if (pad_d != '0)         state_d = ST_PAD;
          else if (conv_len != '0) state_d = ST_EMIT;
          else                     state_d = ST_FIN;
        end
      end
      ST_PAD: begin
        if (bus.out_ready) begin
          pad_d = pad_q - CW'(1);
          if (pad_q == CW'(1)) state_d = (rem_q == '0) ? ST_FIN : ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (bus.out_ready) begin
          rem_d = rem_q - CW'(1);
          pop   = (mode_q != FMT_STR);
          if (rem_q == CW'(1)) state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: pure functions of state, so a stalled beat holds by construction.
  always_comb begin
    bus.req_ready = (state_q == ST_IDLE);
    bus.busy      = (state_q != ST_IDLE);
    bus.done      = (state_q == ST_FIN);
    bus.out_valid = 1'b0;
    bus.out_char  = 8'h00;
    bus.out_last  = 1'b0;
    case (state_q)
      ST_PAD: begin
        bus.out_valid = 1'b1;
        bus.out_char  = ASCII_SPACE;
        bus.out_last  = (pad_q == CW'(1)) && (rem_q == '0);
      end
      ST_EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_char  = (mode_q == FMT_STR) ? str_byte : lifo_top;
        bus.out_last  = (rem_q == CW'(1));
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fmt_stream_formatter.sv
module tb_fmt_stream_formatter;
  import fmt_pkg::*;

  localparam int DATA_W = 32;
  localparam int STR_BYTES = 16;
  localparam int FIELD_W_MAX = 32;
  localparam int WW = $clog2(FIELD_W_MAX + 1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fmt_stream_formatter_if #(.DATA_W(DATA_W), .STR_BYTES(STR_BYTES),
                            .FIELD_W_MAX(FIELD_W_MAX)) ifc ();

  fmt_stream_formatter #(.DATA_W(DATA_W), .STR_BYTES(STR_BYTES),
                         .FIELD_W_MAX(FIELD_W_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] expq[$];   // {last, char}
  bit         doneq[$];  // one per outstanding request: 1 = has beats
  int         exp_n;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- expected-stream builders ----------------
  task automatic exp_begin();
    exp_n = 0;
  endtask
  task automatic exp_byte(input logic [7:0] b);
    expq.push_back({1'b0, b});
    exp_n++;
  endtask
  task automatic exp_pad(input int n);
    for (int i = 0; i < n; i++) exp_byte(8'h20);
  endtask
  task automatic exp_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_byte(s[i]);
  endtask
  task automatic exp_seal();
    logic [8:0] t;
    if (exp_n > 0) begin
      t = expq.pop_back();
      t[8] = 1'b1;
      expq.push_back(t);
    end
    doneq.push_back(exp_n > 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic       stall_q, last_hs_q, done_q;
  logic [7:0] hold_char;
  logic       hold_last;
  logic [8:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0; last_hs_q = 1'b0; done_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("stall_valid", ifc.out_valid, 1'b1);
        chk("stall_char", ifc.out_char, hold_char);
        chk("stall_last", ifc.out_last, hold_last);
      end
      if (done_q) chk("ready_after_done", ifc.req_ready, 1'b1);
      if (ifc.out_valid && ifc.out_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_beat", ifc.out_char, 8'hxx);
        end else begin
          e = expq.pop_front();
          chk("beat_char", ifc.out_char, e[7:0]);
          chk("beat_last", ifc.out_last, e[8]);
        end
      end
      if (ifc.done) begin
        if (doneq.size() == 0) begin
          chk("unexpected_done", 1'b1, 1'b0);
        end else begin
          chk("done_drained", expq.size(), 0);
          chk("done_ready_low", ifc.req_ready, 1'b0);
          if (doneq.pop_front()) chk("done_after_last", last_hs_q, 1'b1);
        end
      end
      stall_q   = ifc.out_valid && !ifc.out_ready;
      hold_char = ifc.out_char;
      hold_last = ifc.out_last;
      last_hs_q = ifc.out_valid && ifc.out_ready && ifc.out_last;
      done_q    = ifc.done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic accept(input fmt_mode_e m, input int w, input logic [31:0] d,
                        input logic [127:0] s);
    int n = 0;
    while (!ifc.req_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("idle_before_req", ifc.req_ready, 1'b1);
    ifc.req_valid = 1'b1;
    ifc.req_mode  = m;
    ifc.req_width = WW'(w);
    ifc.req_data  = d;
    ifc.req_str   = s;
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
  endtask

  // lat = expected cycle of first out_valid (C+1); 0 skips the latency check.
  task automatic issue(input fmt_mode_e m, input int w, input logic [31:0] d,
                       input logic [127:0] s, input int lat, input bit rnd);
    int n;
    accept(m, w, d, s);
    if (lat > 0) begin
      n = 1;
      while (!ifc.out_valid && n < 200) begin @(posedge clk); #1; n++; end
      chk("first_valid_cycle", n, lat);
    end
    n = 0;
    while (!ifc.req_ready && n < 600) begin
      @(posedge clk); #1;
      if (rnd) ifc.out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    ifc.out_ready = 1'b1;
    chk("request_completes", ifc.req_ready, 1'b1);
    chk("sb_empty", expq.size(), 0);
    chk("done_seen", doneq.size(), 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_ready", ifc.req_ready, 1'b1);
    chk("rst_busy", ifc.busy, 1'b0);
    chk("rst_out_valid", ifc.out_valid, 1'b0);
    chk("rst_out_char", ifc.out_char, 8'h00);
    chk("rst_out_last", ifc.out_last, 1'b0);
    chk("rst_done", ifc.done, 1'b0);
  endtask

  logic [127:0] hello, emb;

  initial begin
    rst_n = 1'b0;
    ifc.req_valid = 1'b0;
    ifc.req_mode  = FMT_CHAR;
    ifc.req_width = '0;
    ifc.req_data  = '0;
    ifc.req_str   = '0;
    ifc.out_ready = 1'b1;
    hello = "Hello, World!";
    emb   = {104'h0, 8'h61, 8'h00, 8'h62};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals();

    // DEC 123456789 width 25: 16 spaces, 9 digits, C=9
    exp_begin(); exp_pad(16); exp_str("123456789"); exp_seal();
    issue(FMT_DEC, 25, 32'd123456789, '0, 10, 1'b0);

    // CHAR 'A' width 0
    exp_begin(); exp_str("A"); exp_seal();
    issue(FMT_CHAR, 0, 32'd65, '0, 2, 1'b0);

    // STR "Hello, World!" width 20: 7 spaces
    exp_begin(); exp_pad(7); exp_str("Hello, World!"); exp_seal();
    issue(FMT_STR, 20, '0, hello, 2, 1'b0);

    // zero values
    exp_begin(); exp_str("0"); exp_seal();
    issue(FMT_HEX, 0, 32'd0, '0, 2, 1'b0);
    exp_begin(); exp_str("0"); exp_seal();
    issue(FMT_DEC, 0, 32'd0, '0, 2, 1'b0);

    // content wider than field is not truncated
    exp_begin(); exp_str("deadbeef"); exp_seal();
    issue(FMT_HEX, 4, 32'hDEADBEEF, '0, 9, 1'b0);

    // empty string, width 0: no beats, done still pulses
    exp_begin(); exp_seal();
    issue(FMT_STR, 0, '0, '0, 0, 1'b0);

    // empty string, width 3: pad only, last on third space
    exp_begin(); exp_pad(3); exp_seal();
    issue(FMT_STR, 3, '0, '0, 2, 1'b0);

    // embedded zero byte kept
    exp_begin(); exp_byte(8'h61); exp_byte(8'h00); exp_byte(8'h62); exp_seal();
    issue(FMT_STR, 0, '0, emb, 2, 1'b0);

    // width 40 clamps to 32: 31 spaces then 'x'
    exp_begin(); exp_pad(31); exp_str("x"); exp_seal();
    issue(FMT_CHAR, 40, 32'h78, '0, 2, 1'b0);

    // max value under random backpressure
    exp_begin(); exp_str("4294967295"); exp_seal();
    issue(FMT_DEC, 0, 32'hFFFFFFFF, '0, 11, 1'b1);

    // reset during EMIT of a STR request
    exp_begin(); exp_str("Hello, World!"); exp_seal();
    accept(FMT_STR, 0, '0, hello);
    repeat (3) @(posedge clk);
    #2;
    expq.delete();
    doneq.delete();
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk_reset_vals();

    // next request after abort formats correctly
    exp_begin(); exp_pad(1); exp_str("a5"); exp_seal();
    issue(FMT_HEX, 3, 32'hA5, '0, 3, 1'b0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fmt_stream_formatter.md
# fmt_stream_formatter

Sequential, parametrised ASCII field formatter. It accepts one value per request and streams the formatted text out one character per beat over a valid/ready interface. Supported modes are character, unsigned decimal, lowercase hex and packed string, each right-justified in a minimum field width. It sits between trace/debug producers and the UART/log character sink, and is the hardware equivalent of the `%c`, `%d`, `%h` and `%Ns` formatting used in our simulation-only blocks.

## Interface
Parameters:
- DATA_W, 32, width of numeric operand (≥ 8)
- STR_BYTES, 16, packed string capacity in bytes
- FIELD_W_MAX, 32, maximum field width; WW = $clog2(FIELD_W_MAX+1)

Ports:
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block idle, request accepted on req_valid && req_ready
- req_mode  in  2  fmt_mode_e: CHAR=0, DEC=1, HEX=2, STR=3
- req_width  in  WW  minimum field width, 0 = natural width
- req_data  in  DATA_W  operand for CHAR (bits [7:0]), DEC, HEX
- req_str  in  8*STR_BYTES  packed string, first char in MSB byte
- out_valid  out  1  character beat valid
- out_ready  in  1  sink accepts beat
- out_char  out  8  ASCII character
- out_last  out  1  final beat of this request
- done  out  1  one-cycle pulse when request completes
- busy  out  1  request in progress (= !req_ready)

## Operation
- FSM states: IDLE, CONV, PAD, EMIT, FIN.
- IDLE: req_ready=1. On accept, latch mode, width and operand, then go to CONV.
- CONV, per mode:
  - CHAR: push req_data[7:0]; len=1; 1 cycle.
  - DEC: each cycle push "0"+(q%10), then q=q/10. Exit after the push leaves q==0, so value 0 yields "0". Operand is unsigned. Maximum digits = MAX_DEC_DIGITS(DATA_W), which is 10 for DATA_W=32.
  - HEX: each cycle push the low nibble as "0"–"9"/"a"–"f", then q>>=4. Same termination rule. No leading zeros.
  - STR: 1 cycle. len = STR_BYTES − count of leading (MSB-side) zero bytes. Embedded zero bytes after the first non-zero byte are emitted unchanged.
- pad = (width > len) ? width−len : 0. Content longer than width is never truncated.
- PAD: emit pad spaces (8'h20), then go to EMIT. If pad==0, skip directly to EMIT.
- EMIT: emit buffered characters most-significant-first (DEC/HEX pop the LIFO; STR reads MSB byte first).
- out_last is asserted on the final emitted beat, whether pad or content.
- Empty STR with width 0: zero beats. CONV goes directly to FIN, and done still pulses.
- FIN: done=1 for one cycle, then return to IDLE.
- Backpressure: while out_valid && !out_ready, out_char and out_last hold stable and no state advances.
- No new request is accepted until IDLE. There is no overlap or pipelining between requests.

## Timing
- Reset values: req_ready=1, busy=0, out_valid=0, out_char=8'h00, out_last=0, done=0, FSM=IDLE, buffer cleared.
- Reset asserted mid-request aborts immediately. No done pulse and no further beats are produced.
- Accept at edge 0. CONV occupies cycles 1..C, where:
  - C = 1 for CHAR/STR
  - C = digit count for DEC/HEX
- First out_valid is in cycle C+1. With out_ready held high, the block emits 1 beat/cycle for pad+len beats.
- done pulses in the cycle after the last handshake. req_ready rises the cycle after done.
- Total with no backpressure: 1 + C + pad + len + 1 cycles from accept to req_ready.
- Width arithmetic: pad and len are computed at WW+1 bits with no wrap. req_width > FIELD_W_MAX is clamped to FIELD_W_MAX.

## Structure
- Package fmt_pkg contains:
  - fmt_mode_e
  - ASCII_SPACE and ASCII_0 constants
  - function MAX_DEC_DIGITS(w) = ceil(w·log10 2)
  - hex_ascii(nibble) function
  - the state enum
- Sub-module fmt_char_lifo: a LIFO of depth max(MAX_DEC_DIGITS(DATA_W), DATA_W/4) with push/pop/count. The top level owns the FSM, pad counter and STR byte index.

## Test plan
- DEC 123456789, width 25: 16 spaces then "123456789"; out_last on "9"; C=9; done 1 cycle later.
- CHAR 65, width 0: single beat "A" with out_last=1; first out_valid 2 cycles after accept.
- STR "Hello, World!" in STR_BYTES=16 (3 leading zero bytes), width 20: 7 spaces then "Hello, World!"; 20 beats.
- HEX 0 and DEC 0, width 0: single "0". HEX 32'hDEADBEEF, width 4: "deadbeef" with no truncation. STR all-zero, width 0: no beats, done pulses.
- Random out_ready toggling during DEC 4294967295: out_char and out_last stable while stalled; output exactly "4294967295".
- Assert rst_n low during EMIT of a STR request: outputs return to reset values asynchronously; no done pulse; the next request formats correctly.
